// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller: access-size encodings,
// controller FSM states and the byte-lane enable helper.
package mem_pkg;

    // Access size encodings carried on req_size (log2 of the access bytes)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // True when byte lane 'lane' is covered by an access of 2**size bytes
    // starting at byte offset 'offset' within the word.
    function automatic logic lane_en(input int lane, input int offset, input int size);
        return (lane >= offset) && (lane < offset + (1 << size));
    endfunction

endpackage

// File: rtl/mem_lane_array.sv
// Word-organised storage with per-byte-lane write enables and a registered
// (synchronous) read port sharing one address.
module mem_lane_array #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [DATA_WID/8-1:0]   wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WID-1:0]     addr,
    input  logic [DATA_WID-1:0]     wr_data,
    output logic [DATA_WID-1:0]     rd_data
);

    localparam int BYTES = DATA_WID / 8;

    logic [DATA_WID-1:0] mem_q [2**ADDR_WID];
    logic [DATA_WID-1:0] rd_data_q;

    // Byte-lane write and synchronous read; the read register holds between reads.
    // NOTE: the array and its read register have no reset; clearing a RAM is not
    // free in silicon and the controller never exposes rd_data before a read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[addr];
        end
        for (int b = 0; b < BYTES; b++) begin
            if (wr_en && wr_be[b]) begin
                mem_q[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the MEM stage: one outstanding request,
// configurable read latency, byte/half/word access with extension and
// misalignment reporting.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 10,
    parameter int LATENCY  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_write,
    input  logic [1:0]                             req_size,
    input  logic                                   req_signed,
    input  logic [ADDR_WID+$clog2(DATA_WID/8)-1:0] req_addr,
    input  logic [DATA_WID-1:0]                    req_wdata,
    output logic                                   resp_valid,
    output logic [DATA_WID-1:0]                    resp_rdata,
    output logic                                   resp_err
);

    localparam int BYTES   = DATA_WID / 8;
    localparam int OFF_WID = $clog2(BYTES);
    localparam int CNT_WID = 4;

    state_e               state_q, state_d;
    logic [CNT_WID-1:0]   cnt_q, cnt_d;
    logic [OFF_WID-1:0]   ld_off_q, ld_off_d;
    logic [1:0]           ld_size_q, ld_size_d;
    logic                 ld_signed_q, ld_signed_d;
    logic                 ld_zero_q, ld_zero_d;
    logic                 err_q, err_d;
    logic [DATA_WID-1:0]  rdata_hold_q, rdata_hold_d;
    logic                 err_hold_q, err_hold_d;

    logic [OFF_WID-1:0]   req_off;
    logic [ADDR_WID-1:0]  req_word;
    logic                 accept;
    logic                 req_err;
    logic [BYTES-1:0]     wr_be;
    logic [DATA_WID-1:0]  wr_data;
    logic [DATA_WID-1:0]  rd_data;
    logic [DATA_WID-1:0]  shifted;
    logic [DATA_WID-1:0]  ext_data;
    logic                 sign_bit;
    int                   nbits;

    assign req_off  = req_addr[OFF_WID-1:0];
    assign req_word = req_addr[ADDR_WID+OFF_WID-1:OFF_WID];
    assign accept   = req_valid && req_ready;
    assign req_err  = (int'(req_size) > OFF_WID) ||
                      ((int'(req_off) & ((1 << int'(req_size)) - 1)) != 0);
    assign wr_data  = req_wdata << {req_off, 3'b000};

    // Byte-lane enables for the accepted store.
    always_comb begin
        for (int b = 0; b < BYTES; b++) begin
            wr_be[b] = lane_en(b, int'(req_off), int'(req_size));
        end
    end

    mem_lane_array #(
        .DATA_WID (DATA_WID),
        .ADDR_WID (ADDR_WID)
    ) u_array (
        .clk     (clk),
        .wr_en   (accept && req_write && !req_err),
        .wr_be   (wr_be),
        .rd_en   (accept && !req_write && !req_err),
        .addr    (req_word),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    // Next state, latency counter and capture of the accepted request's attributes.
    // NOTE: every signal gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_off_d    = ld_off_q;
        ld_size_d   = ld_size_q;
        ld_signed_d = ld_signed_q;
        ld_zero_d   = ld_zero_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    ld_off_d    = req_off;
                    ld_size_d   = req_size;
                    ld_signed_d = req_signed;
                    ld_zero_d   = req_write || req_err;
                    err_d       = req_err;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_WID'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_WID'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_WID'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Align the read word to the accessed bytes and sign/zero-extend it.
    always_comb begin
        shifted  = rd_data >> {ld_off_q, 3'b000};
        nbits    = 8 << int'(ld_size_q);
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_WID; i++) begin
            if (i == nbits - 1) begin
                sign_bit = shifted[i];
            end
        end
        for (int i = 0; i < DATA_WID; i++) begin
            ext_data[i] = (i < nbits) ? shifted[i] : (ld_signed_q & sign_bit);
        end
    end

    // Response outputs are live only in RESP and otherwise hold the last response.
    assign req_ready    = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rdata   = resp_valid ? (ld_zero_q ? '0 : ext_data) : rdata_hold_q;
    assign resp_err     = resp_valid ? err_q : err_hold_q;
    assign rdata_hold_d = resp_rdata;
    assign err_hold_d   = resp_err;

    // Controller state registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ld_off_q     <= '0;
            ld_size_q    <= '0;
            ld_signed_q  <= 1'b0;
            ld_zero_q    <= 1'b0;
            err_q        <= 1'b0;
            rdata_hold_q <= '0;
            err_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_off_q     <= ld_off_d;
            ld_size_q    <= ld_size_d;
            ld_signed_q  <= ld_signed_d;
            ld_zero_q    <= ld_zero_d;
            err_q        <= err_d;
            rdata_hold_q <= rdata_hold_d;
            err_hold_q   <= err_hold_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: one instance with LATENCY=1 and one
// with LATENCY=3, checked against a byte-array reference model.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    int          sel;

    logic        req_valid1, req_valid3;
    logic        ready1, ready3, rvalid1, rvalid3, err1, err3;
    logic [31:0] rdata1, rdata3;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [7:0]  mdl [0:1][0:4095];

    always #5 clk = ~clk;

    assign req_valid1 = req_valid && (sel == 0);
    assign req_valid3 = req_valid && (sel == 1);

    data_mem_ctrl #(.DATA_WID(DW), .ADDR_WID(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(ready1),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid1),
        .resp_rdata(rdata1), .resp_err(err1)
    );

    data_mem_ctrl #(.DATA_WID(DW), .ADDR_WID(AW), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(ready3),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvalid3),
        .resp_rdata(rdata3), .resp_err(err3)
    );

    function automatic logic get_ready(input int d);
        return (d == 1) ? ready3 : ready1;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 1) ? rvalid3 : rvalid1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 1) ? err3 : err1;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 1) ? rdata3 : rdata1;
    endfunction
    function automatic int lat(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as bytes, loads assembled little-endian then extended.
    function automatic bit model_err(input logic [1:0] sz, input logic [11:0] addr);
        return (int'(sz) > 2) || ((int'(addr) % (1 << int'(sz))) != 0);
    endfunction

    task automatic model_store(input int d, input logic [11:0] addr, input logic [1:0] sz,
                               input logic [31:0] wd);
        for (int k = 0; k < (1 << int'(sz)); k++) mdl[d][int'(addr) + k] = wd[8*k +: 8];
    endtask

    function automatic logic [31:0] model_load(input int d, input logic [11:0] addr,
                                               input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        int n;
        n = 1 << int'(sz);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[d][int'(addr) + k];
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // One complete request/response transaction on instance d.
    task automatic do_req(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          waited, edges;
        exp_err = model_err(sz, addr);
        exp_rd  = '0;
        if (!exp_err) begin
            if (wr) model_store(d, addr, sz, wd);
            else    exp_rd = model_load(d, addr, sz, sg);
        end
        @(negedge clk);
        sel = d; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        waited = 0;
        while (!get_ready(d) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 32'(waited < 20), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        edges = 0;
        while (!get_valid(d) && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("resp_latency", 32'(edges), 32'(lat(d) - 1));
        check("resp_rdata", get_rdata(d), exp_rd);
        check("resp_err", 32'(get_err(d)), 32'(exp_err));
        check("ready_in_resp", 32'(get_ready(d)), 32'd1);
        last_rdata = get_rdata(d);
        last_err   = get_err(d);
        @(posedge clk);
        #1;
        check("pulse_width", 32'(get_valid(d)), 32'd0);
        check("rdata_hold", get_rdata(d), exp_rd);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bb_addr [3];
        logic [31:0] bb_exp  [3];
        int          acc [$];
        int          rsp [$];
        int          idx, spurious;
        logic        rdy, acc_now;
        int          d;
        bit          wr;
        logic [1:0]  sz;

        rst_n = 1'b0; sel = 0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        #12;
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_valid", 32'(rvalid1), 32'd0);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store/load, LATENCY = 1
        do_req(0, 1, SZ_WORD, 0, 12'h010, 32'hDEAD_BEEF);
        do_req(0, 0, SZ_WORD, 0, 12'h010, 32'h0);
        check("lw10", last_rdata, 32'hDEAD_BEEF);

        // Byte stores and signed/unsigned byte loads
        do_req(0, 1, SZ_WORD, 0, 12'h010, 32'h0);
        do_req(0, 1, SZ_BYTE, 0, 12'h011, 32'h12);
        do_req(0, 0, SZ_WORD, 0, 12'h010, 32'h0);
        check("lw10_after_sb", last_rdata, 32'h0000_1200);
        do_req(0, 0, SZ_BYTE, 1, 12'h011, 32'h0);
        check("lb11", last_rdata, 32'h0000_0012);
        do_req(0, 1, SZ_BYTE, 0, 12'h013, 32'h80);
        do_req(0, 0, SZ_BYTE, 1, 12'h013, 32'h0);
        check("lb13", last_rdata, 32'hFFFF_FF80);
        do_req(0, 0, SZ_BYTE, 0, 12'h013, 32'h0);
        check("lbu13", last_rdata, 32'h0000_0080);

        // Half-word store into the upper half
        do_req(0, 1, SZ_WORD, 0, 12'h020, 32'h1234_5678);
        do_req(0, 1, SZ_HALF, 0, 12'h022, 32'h8001);
        do_req(0, 0, SZ_HALF, 1, 12'h022, 32'h0);
        check("lh22", last_rdata, 32'hFFFF_8001);
        do_req(0, 0, SZ_HALF, 0, 12'h022, 32'h0);
        check("lhu22", last_rdata, 32'h0000_8001);
        do_req(0, 0, SZ_WORD, 0, 12'h020, 32'h0);
        check("lw20", last_rdata, 32'h8001_5678);

        // Misalignment and illegal size
        do_req(0, 1, SZ_WORD, 0, 12'h000, 32'hCAFE_F00D);
        do_req(0, 0, SZ_WORD, 0, 12'h002, 32'h0);
        check("lw02_err", 32'(last_err), 32'd1);
        do_req(0, 1, SZ_HALF, 0, 12'h001, 32'hBEEF);
        check("sh01_err", 32'(last_err), 32'd1);
        do_req(0, 1, 2'd3, 0, 12'h000, 32'hFFFF_FFFF);
        check("size3_err", 32'(last_err), 32'd1);
        do_req(0, 0, SZ_WORD, 0, 12'h000, 32'h0);
        check("lw00_unchanged", last_rdata, 32'hCAFE_F00D);

        // Back-to-back loads with req_valid held, LATENCY = 3
        bb_addr[0] = 12'h050; bb_addr[1] = 12'h054; bb_addr[2] = 12'h058;
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1, SZ_WORD, 0, bb_addr[i], $urandom);
            bb_exp[i] = model_load(1, bb_addr[i], SZ_WORD, 0);
        end
        @(negedge clk);
        sel = 1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = bb_addr[0]; req_valid = 1'b1; idx = 0;
        for (int c = 0; c < 16; c++) begin
            rdy = ready3;
            @(posedge clk);
            acc_now = req_valid && rdy;
            #1;
            if (acc_now) begin
                acc.push_back(c);
                idx++;
                if (idx < 3) req_addr = bb_addr[idx];
                else         req_valid = 1'b0;
            end
            if (rvalid3) begin
                rsp.push_back(c);
                if (rsp.size() <= 3) check("b2b_rdata", rdata3, bb_exp[rsp.size()-1]);
            end
            @(negedge clk);
        end
        check("b2b_accepts", 32'(acc.size()), 32'd3);
        check("b2b_responses", 32'(rsp.size()), 32'd3);
        if (acc.size() == 3 && rsp.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("b2b_resp_delay", 32'(rsp[i] - acc[i]), 32'd2);
                if (i > 0) check("b2b_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
            end
        end

        // Reset during WAIT, LATENCY = 3
        do_req(1, 1, SZ_WORD, 0, 12'h040, 32'h1357_2468);
        do_req(1, 0, SZ_WORD, 0, 12'h040, 32'h0);
        @(negedge clk);
        sel = 1; req_write = 1'b0; req_size = SZ_WORD; req_addr = 12'h040; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("wait_state_ready", 32'(ready3), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rvalid3), 32'd0);
        check("midrst_rdata", rdata3, 32'd0);
        check("midrst_err", 32'(err3), 32'd0);
        check("midrst_ready", 32'(ready3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (rvalid3) spurious++;
        end
        check("aborted_no_resp", 32'(spurious), 32'd0);
        do_req(1, 0, SZ_WORD, 0, 12'h040, 32'h0);
        check("store_survives_rst", last_rdata, 32'h1357_2468);

        // Randomised traffic in a prefilled region on both instances
        for (int dd = 0; dd < 2; dd++) begin
            for (int w = 0; w < 16; w++) do_req(dd, 1, SZ_WORD, 0, 12'(12'h100 + 4*w), $urandom);
        end
        for (int i = 0; i < 150; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(d, wr, sz, 1'($urandom_range(0, 1)), 12'(12'h100 + $urandom_range(0, 63)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
